// File: rtl/output_write_scheduler_pkg.sv
// output_layer_pkg: shared FSM encoding, beat size and latched-config type for the output writer.
// Rev 1.0
`default_nettype none
package output_layer_pkg;

  localparam int         BEAT_BYTES    = 8;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  typedef struct packed {
    logic [2:0]  nlayers;
    logic [7:0]  row_size;
    logic [7:0]  col_size;
    logic [15:0] pitch;
    logic [3:0]  bpr;
    logic [7:0]  wlen;
  } cfg_t;

endpackage
`default_nettype wire

// File: rtl/output_write_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or above the pointer with wrap.
// Rev 1.0
`default_nettype none
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = PW'((int'(i_ptr) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/output_write_scheduler.sv
// output_write_scheduler: round-robin AXI write-burst sequencer for several output feature maps.
// Rev 1.0
`default_nettype none
module output_write_scheduler
  import output_layer_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int ADDR_W     = 32,
  parameter int DCOUNT_W   = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [ADDR_W-1:0]            layer_stride,
  input  logic [2:0]                   no_of_layers,
  input  logic [7:0]                   row_size,
  input  logic [7:0]                   col_size,
  input  logic [15:0]                  allocated_space_per_row,
  input  logic [3:0]                   burst_per_row,
  input  logic [7:0]                   write_burst_len,
  input  logic [NUM_LAYERS*DCOUNT_W-1:0] fifo_dcount,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [1:0]                   cmd_layer,
  output logic [ADDR_W-1:0]            cmd_addr,
  output logic [7:0]                   cmd_len,
  output logic [15:0]                  cmd_bytes,
  input  logic                         cmd_done,
  input  logic                         cmd_err,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  state_e                r_state, w_state_nxt;
  cfg_t                  r_cfg;
  logic [ADDR_W-1:0]     r_base, r_stride;
  logic [7:0]            r_row   [NUM_LAYERS];
  logic [3:0]            r_burst [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] r_fin;
  logic [1:0]            r_rr, r_layer;
  logic [ADDR_W-1:0]     r_addr;
  logic [7:0]            r_len;
  logic [15:0]           r_bytes;
  logic                  r_err;

  logic [ADDR_W-1:0]     w_full_b, w_addr;
  logic [NUM_LAYERS-1:0] w_active, w_skip, w_elig, w_grant;
  logic [15:0]           w_bytes [NUM_LAYERS];
  logic [15:0]           w_sel_bytes;
  logic [7:0]            w_len;
  logic [1:0]            w_gidx, w_adv_idx;
  logic                  w_any, w_adv, w_row_end, w_last, w_all_fin;

  assign w_full_b = ADDR_W'((32'(r_cfg.wlen) + 32'd1) * 32'(BEAT_BYTES));

  // Each layer's current burst size; a burst starting past the row end is a skip.
  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    logic [ADDR_W-1:0] w_off, w_rem;
    assign w_off       = ADDR_W'(r_burst[k]) * w_full_b;
    assign w_rem       = ADDR_W'(r_cfg.row_size) - w_off;
    assign w_active[k] = (k < int'(r_cfg.nlayers));
    assign w_skip[k]   = (w_off >= ADDR_W'(r_cfg.row_size));
    assign w_bytes[k]  = w_skip[k] ? 16'd0 : ((w_rem < w_full_b) ? w_rem[15:0] : w_full_b[15:0]);
    assign w_elig[k]   = w_active[k] && !r_fin[k] &&
                         (w_skip[k] || (ADDR_W'(fifo_dcount[k*DCOUNT_W +: DCOUNT_W]) >= ADDR_W'(w_bytes[k])));
  end

  rr_arbiter #(.N(NUM_LAYERS), .PW(2)) u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_rr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int k = 0; k < NUM_LAYERS; k++)
      if (w_grant[k]) w_gidx = 2'(k);
  end

  assign w_any       = |w_grant;
  assign w_sel_bytes = w_bytes[w_gidx];
  assign w_len       = 8'((w_sel_bytes + 16'(BEAT_BYTES - 1)) / 16'(BEAT_BYTES) - 16'd1);
  assign w_addr      = r_base + ADDR_W'(w_gidx) * r_stride
                     + ADDR_W'(r_row[w_gidx]) * ADDR_W'(r_cfg.pitch)
                     + ADDR_W'(r_burst[w_gidx]) * w_full_b;

  // Counters advance on a completed burst or a silently skipped one.
  assign w_adv     = ((r_state == ST_ARB) && w_any && w_skip[w_gidx]) || ((r_state == ST_WAIT) && cmd_done);
  assign w_adv_idx = (r_state == ST_ARB) ? w_gidx : r_layer;
  assign w_row_end = ((5'(r_burst[w_adv_idx]) + 5'd1) == 5'(r_cfg.bpr));
  assign w_last    = w_row_end && ((9'(r_row[w_adv_idx]) + 9'd1) == 9'(r_cfg.col_size));

  always_comb begin
    w_all_fin = 1'b1;
    for (int k = 0; k < NUM_LAYERS; k++)
      if (w_active[k] && !(r_fin[k] || ((2'(k) == w_adv_idx) && w_last))) w_all_fin = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_ARB;
      ST_ARB: begin
        if (w_any) begin
          if (w_skip[w_gidx]) w_state_nxt = w_all_fin ? ST_FIN : ST_ARB;
          else                w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: if (cmd_ready) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (cmd_done) w_state_nxt = w_all_fin ? ST_FIN : ST_ARB;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      ST_ARB, ST_WAIT: busy = 1'b1;
      ST_ISSUE: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg    <= '0;
      r_base   <= '0;
      r_stride <= '0;
      r_fin    <= '0;
      r_rr     <= '0;
      r_layer  <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_bytes  <= '0;
      r_err    <= 1'b0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
        r_row[k]   <= '0;
        r_burst[k] <= '0;
      end
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_cfg    <= '{nlayers: no_of_layers, row_size: row_size, col_size: col_size,
                      pitch: allocated_space_per_row, bpr: burst_per_row, wlen: write_burst_len};
        r_base   <= base_addr;
        r_stride <= layer_stride;
        r_fin    <= '0;
        r_rr     <= '0;
        r_err    <= 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
          r_row[k]   <= '0;
          r_burst[k] <= '0;
        end
      end
      if ((r_state == ST_ARB) && w_any && !w_skip[w_gidx]) begin
        r_layer <= w_gidx;
        r_addr  <= w_addr;
        r_len   <= w_len;
        r_bytes <= w_sel_bytes;
      end
      if ((r_state == ST_ISSUE) && cmd_ready) begin
        if ((3'(r_layer) + 3'd1) >= r_cfg.nlayers) r_rr <= '0;
        else                                       r_rr <= r_layer + 2'd1;
      end
      if (w_adv) begin
        if (w_row_end) begin
          r_burst[w_adv_idx] <= '0;
          if (w_last) r_fin[w_adv_idx]   <= 1'b1;
          else        r_row[w_adv_idx]   <= r_row[w_adv_idx] + 8'd1;
        end else begin
          r_burst[w_adv_idx] <= r_burst[w_adv_idx] + 4'd1;
        end
        if (r_state == ST_WAIT) r_err <= r_err | cmd_err;
      end
    end
  end

  assign cmd_layer = r_layer;
  assign cmd_addr  = r_addr;
  assign cmd_len   = r_len;
  assign cmd_bytes = r_bytes;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_output_write_scheduler.sv
// tb_output_write_scheduler: randomized scoreboard bench against a burst-list reference model.
// Rev 1.0
`default_nettype none
module tb_output_write_scheduler;

  localparam int NL = 4;
  localparam int DW = 10;

  logic             clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [31:0]      base_addr = '0, layer_stride = '0;
  logic [2:0]       no_of_layers = 3'd1;
  logic [7:0]       row_size = 8'd1, col_size = 8'd1, write_burst_len = 8'd0;
  logic [15:0]      allocated_space_per_row = '0;
  logic [3:0]       burst_per_row = 4'd1;
  logic [NL*DW-1:0] fifo_dcount = '0;
  logic             cmd_valid, cmd_ready = 1'b0, cmd_done = 1'b0, cmd_err = 1'b0;
  logic [1:0]       cmd_layer;
  logic [31:0]      cmd_addr;
  logic [7:0]       cmd_len;
  logic [15:0]      cmd_bytes;
  logic             busy, done, err;

  output_write_scheduler #(.NUM_LAYERS(NL), .ADDR_W(32), .DCOUNT_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .layer_stride(layer_stride),
    .no_of_layers(no_of_layers), .row_size(row_size), .col_size(col_size),
    .allocated_space_per_row(allocated_space_per_row), .burst_per_row(burst_per_row),
    .write_burst_len(write_burst_len), .fifo_dcount(fifo_dcount), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_layer(cmd_layer), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_bytes(cmd_bytes), .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_done;
    logic [1:0]  layer;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [15:0] bytes;
  } exp_t;

  exp_t sb[$];
  exp_t lq[NL][$];
  int   dc[NL];
  int   m_rr, m_nl;
  int   checks = 0, errors = 0, done_cnt = 0;
  exp_t m_e;

  // Monitor: every accepted command or done pulse is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL cmd unexpected: layer %0d addr %h len %0d bytes %0d", cmd_layer, cmd_addr, cmd_len, cmd_bytes);
      end else begin
        m_e = sb.pop_front();
        if (m_e.is_done || cmd_layer !== m_e.layer || cmd_addr !== m_e.addr ||
            cmd_len !== m_e.len || cmd_bytes !== m_e.bytes) begin
          errors++;
          $display("FAIL cmd got layer %0d addr %h len %0d bytes %0d, exp done %0d layer %0d addr %h len %0d bytes %0d",
                   cmd_layer, cmd_addr, cmd_len, cmd_bytes, m_e.is_done, m_e.layer, m_e.addr, m_e.len, m_e.bytes);
        end
      end
    end
    if (done) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0 || !sb[0].is_done) begin
        errors++;
        $display("FAIL done pulse got 1 exp pending cmd (queue %0d)", sb.size());
      end else begin
        m_e = sb.pop_front();
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic abort_run(input string msg);
    errors++;
    $display("FAIL %s got timeout exp event", msg);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic drive_dc();
    for (int k = 0; k < NL; k++) fifo_dcount[k*DW +: DW] = DW'(dc[k]);
  endtask

  // Reference: each active layer owns the ordered list of its non-empty bursts.
  function automatic int build_model();
    int full, off, total;
    exp_t e;
    full  = (int'(write_burst_len) + 1) * 8;
    total = 0;
    m_nl  = int'(no_of_layers);
    m_rr  = 0;
    for (int k = 0; k < NL; k++) lq[k].delete();
    for (int k = 0; k < m_nl; k++)
      for (int r = 0; r < int'(col_size); r++)
        for (int b = 0; b < int'(burst_per_row); b++) begin
          off = b * full;
          if (off < int'(row_size)) begin
            e         = '0;
            e.layer   = 2'(k);
            e.bytes   = 16'(((int'(row_size) - off) < full) ? (int'(row_size) - off) : full);
            e.len     = 8'((int'(e.bytes) + 7) / 8 - 1);
            e.addr    = base_addr + 32'(k) * layer_stride + 32'(r) * 32'(allocated_space_per_row) + 32'(off);
            lq[k].push_back(e);
            total++;
          end
        end
    return total;
  endfunction

  function automatic bit model_pick(output exp_t e);
    int k;
    e = '0;
    for (int i = 0; i < m_nl; i++) begin
      k = (m_rr + i) % m_nl;
      if (lq[k].size() > 0 && dc[k] >= int'(lq[k][0].bytes)) begin
        e    = lq[k].pop_front();
        m_rr = (k + 1) % m_nl;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic predict_and_push();
    exp_t e;
    int   left = 0;
    bit   got;
    for (int k = 0; k < NL; k++) left += lq[k].size();
    if (left == 0) begin
      e = '0;
      e.is_done = 1'b1;
      sb.push_back(e);
    end else begin
      got = model_pick(e);
      if (!got) begin
        for (int k = 0; k < NL; k++) dc[k] = 1023;
        drive_dc();
        got = model_pick(e);
      end
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic serve_handshake();
    int n = 0;
    while (!cmd_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 300) abort_run("cmd_valid_wait");
    end
    if ($urandom_range(0, 3) == 0) begin
      cmd_done = 1'b1; cmd_err = 1'b1;
      @(posedge clk); #1 cmd_done = 1'b0; cmd_err = 1'b0;
    end
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    cmd_ready = 1'b1;
    @(posedge clk); #1 cmd_ready = 1'b0;
  endtask

  task automatic set_cfg(input int nl, input logic [31:0] b, input logic [31:0] s, input int row,
                         input int col, input int pitch, input int bpr, input int len, input int d);
    no_of_layers = 3'(nl); base_addr = b; layer_stride = s; row_size = 8'(row); col_size = 8'(col);
    allocated_space_per_row = 16'(pitch); burst_per_row = 4'(bpr); write_burst_len = 8'(len);
    for (int k = 0; k < NL; k++) dc[k] = (k < nl) ? d : int'($urandom_range(0, 1023));
  endtask

  // mode 0: static FIFO levels, 1: layer0 refills after 3 bursts, 2: random levels and config scramble.
  task automatic run_frame(input int mode, input int err_idx, input bit rnd_err);
    int total, served = 0, d0, n = 0;
    bit exp_err = 1'b0, eb;
    drive_dc();
    total = build_model();
    predict_and_push();
    d0 = done_cnt;
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err_clear", 32'(err), 32'd0);
    if (mode == 2) begin
      row_size = 8'($urandom); col_size = 8'($urandom); burst_per_row = 4'($urandom);
      write_burst_len = 8'($urandom); base_addr = $urandom; no_of_layers = 3'($urandom);
    end
    while (served < total) begin
      serve_handshake();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      served++;
      if (mode == 1 && served == 3) dc[0] = 500;
      if (mode == 2) for (int k = 0; k < NL; k++) dc[k] = int'($urandom_range(0, 300));
      drive_dc();
      predict_and_push();
      eb = (served - 1 == err_idx) || (rnd_err && $urandom_range(0, 7) == 0);
      exp_err |= eb;
      cmd_done = 1'b1; cmd_err = eb;
      @(posedge clk); #1 cmd_done = 1'b0; cmd_err = 1'b0;
    end
    while (done_cnt == d0) begin
      @(posedge clk); #1;
      n++;
      if (n > 200) abort_run("done_wait");
    end
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_err", 32'(err), 32'(exp_err));
    chk("end_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cmd_addr", cmd_addr, 32'd0);
    chk("rst_cmd_fields", {14'd0, cmd_layer, cmd_len, 8'd0}, 32'd0);
    chk("rst_cmd_bytes", 32'(cmd_bytes), 32'd0);

    set_cfg(1, 32'h1000, 32'h0, 55, 55, 64, 1, 7, 500);
    run_frame(0, -1, 1'b0);
    set_cfg(2, 32'h1000, 32'h4000, 55, 4, 64, 1, 7, 500);
    run_frame(0, -1, 1'b0);
    set_cfg(2, 32'h1000, 32'h4000, 55, 4, 64, 1, 7, 500);
    dc[0] = 40;
    run_frame(1, -1, 1'b0);
    set_cfg(1, 32'h2000, 32'h0, 100, 3, 128, 2, 7, 500);
    run_frame(0, -1, 1'b0);
    set_cfg(3, 32'h8000, 32'h1000, 55, 3, 64, 1, 7, 500);
    run_frame(0, 2, 1'b0);
    set_cfg(3, 32'h0, 32'h300, 20, 2, 32, 3, 1, 100);
    run_frame(2, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      set_cfg(int'($urandom_range(1, 4)), $urandom, $urandom, int'($urandom_range(1, 255)),
              int'($urandom_range(1, 5)), int'($urandom_range(0, 65535)), int'($urandom_range(1, 4)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 300)));
      run_frame(2, -1, 1'b1);
    end

    set_cfg(2, 32'h4000, 32'h800, 40, 3, 64, 1, 3, 500);
    drive_dc();
    void'(build_model());
    predict_and_push();
    pulse_start();
    serve_handshake();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("midrst_cmd_addr", cmd_addr, 32'd0);
    sb.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));
    set_cfg(2, 32'h4000, 32'h800, 40, 3, 64, 1, 3, 500);
    run_frame(0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
